// File: rtl/pim_result_collector_pkg.sv
// Shared constants, state encoding and tile address helper for the PIM result collector
// and its round-robin arbiter.
package pim_result_collector_pkg;

   localparam int NUM_OF_PIM_UNITS = 4;
   localparam int MATRIX_SIZE      = 8;
   localparam int WIDTH            = 32;
   localparam int LEN              = 10;

   function automatic int isqrt(input int n);
      int r;
      r = 0;
      for (int i = 0; i <= n; i++) begin
         if (i * i <= n) begin
            r = i;
         end else begin
            r = r;
         end
      end
      return r;
   endfunction

   localparam int GRID_SIZE  = isqrt(NUM_OF_PIM_UNITS);
   localparam int CHUNK_SIZE = MATRIX_SIZE / GRID_SIZE;
   localparam int TILE_ELEMS = CHUNK_SIZE * CHUNK_SIZE;
   localparam int PTR_W      = (NUM_OF_PIM_UNITS > 1) ? $clog2(NUM_OF_PIM_UNITS) : 1;
   localparam int CNT_W      = $clog2(TILE_ELEMS + 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      COLLECT = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } collector_state_t;

   // Row-major address of element 'elem' of unit 'unit' inside the full matrix; wraps mod 2^LEN.
   function automatic logic [LEN-1:0] elem_addr(input logic [LEN-1:0] base, input int unit,
                                                input int elem);
      int br;
      int bc;
      int r;
      int c;
      int off;
      br  = unit / GRID_SIZE;
      bc  = unit % GRID_SIZE;
      r   = elem / CHUNK_SIZE;
      c   = elem % CHUNK_SIZE;
      off = (br * CHUNK_SIZE + r) * MATRIX_SIZE + bc * CHUNK_SIZE + c;
      return base + off[LEN-1:0];
   endfunction

endpackage

// File: rtl/pim_result_collector_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after ptr and
// reports the pointer that follows the winner (ptr unchanged when nobody requests).
module pim_rr_arbiter #(
   parameter int N     = 4,
   parameter int PTR_W = 2
) (
   input  logic [N-1:0]     req,
   input  logic [PTR_W-1:0] ptr,
   output logic [N-1:0]     grant,
   output logic [PTR_W-1:0] next_ptr
);

   logic             found;
   logic [PTR_W-1:0] idx;

   // Scan requesters starting at ptr, wrapping, and pick the first one.
   always_comb begin
      grant    = '0;
      next_ptr = ptr;
      found    = 1'b0;
      idx      = '0;
      for (int i = 0; i < N; i++) begin
         idx = PTR_W'((int'(ptr) + i) % N);
         if (!found && req[idx]) begin
            grant[idx] = 1'b1;
            next_ptr   = PTR_W'((int'(idx) + 1) % N);
            found      = 1'b1;
         end else begin
            found = found;
         end
      end
   end

endmodule

// File: rtl/pim_result_collector.sv
// Collects output tiles from the PIM unit array and writes each element, one per cycle,
// to its row-major location in the result memory.
module pim_result_collector
   import pim_result_collector_pkg::*;
(
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     start,
   input  logic [LEN-1:0]                           result_base,
   input  logic [NUM_OF_PIM_UNITS-1:0]              pim_valid,
   input  logic [NUM_OF_PIM_UNITS-1:0][WIDTH-1:0]   pim_data,
   output logic [NUM_OF_PIM_UNITS-1:0]              pim_ready,
   output logic                                     mem_we,
   output logic [LEN-1:0]                           mem_addr,
   output logic [WIDTH-1:0]                         mem_wdata,
   output logic                                     busy,
   output logic                                     done
);

   localparam int N = NUM_OF_PIM_UNITS;

   collector_state_t          state_q, state_d;
   logic [PTR_W-1:0]          rr_ptr_q, rr_ptr_d;
   logic [LEN-1:0]            base_q, base_d;
   logic [N-1:0][CNT_W-1:0]   cnt_q, cnt_d;
   logic                      mem_we_q, mem_we_d;
   logic [LEN-1:0]            mem_addr_q, mem_addr_d;
   logic [WIDTH-1:0]          mem_wdata_q, mem_wdata_d;
   logic                      busy_q, busy_d;
   logic                      done_q, done_d;

   logic [N-1:0]              req;
   logic [N-1:0]              grant;
   logic [PTR_W-1:0]          arb_next_ptr;
   logic                      xfer;
   logic [PTR_W-1:0]          xfer_unit;
   logic                      all_full;

   // A unit may request only while collecting and before its tile is complete.
   always_comb begin
      req = '0;
      for (int u = 0; u < N; u++) begin
         req[u] = (state_q == COLLECT) && pim_valid[u] && (cnt_q[u] < CNT_W'(TILE_ELEMS));
      end
   end

   pim_rr_arbiter #(
      .N     (N),
      .PTR_W (PTR_W)
   ) u_arb (
      .req      (req),
      .ptr      (rr_ptr_q),
      .grant    (grant),
      .next_ptr (arb_next_ptr)
   );

   assign pim_ready = grant;
   assign xfer      = |grant;

   // Encode the one-hot grant into the winning unit index.
   always_comb begin
      xfer_unit = '0;
      for (int u = 0; u < N; u++) begin
         if (grant[u]) begin
            xfer_unit = PTR_W'(u);
         end else begin
            xfer_unit = xfer_unit;
         end
      end
   end

   // Next-state, counter, pointer and registered write-port logic.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      base_d      = base_q;
      cnt_d       = cnt_q;
      mem_we_d    = 1'b0;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      all_full    = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = COLLECT;
               base_d  = result_base;
               cnt_d   = '0;
            end else begin
               state_d = IDLE;
            end
         end
         COLLECT: begin
            if (xfer) begin
               cnt_d[xfer_unit] = cnt_q[xfer_unit] + CNT_W'(1);
               rr_ptr_d         = arb_next_ptr;
               mem_we_d         = 1'b1;
               mem_addr_d       = elem_addr(base_q, int'(xfer_unit), int'(cnt_q[xfer_unit]));
               mem_wdata_d      = pim_data[xfer_unit];
            end else begin
               rr_ptr_d = rr_ptr_q;
            end
            all_full = 1'b1;
            for (int u = 0; u < N; u++) begin
               all_full = all_full && (cnt_d[u] == CNT_W'(TILE_ELEMS));
            end
            if (all_full) begin
               state_d = FLUSH;
            end else begin
               state_d = COLLECT;
            end
         end
         FLUSH:   state_d = DONE;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d == COLLECT) || (state_d == FLUSH);
      done_d = (state_d == DONE);
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         rr_ptr_q    <= '0;
         base_q      <= '0;
         cnt_q       <= '0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         base_q      <= base_d;
         cnt_q       <= cnt_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
      end
   end

   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;

endmodule

// File: tb/tb_pim_result_collector.sv
// Self-checking bench for pim_result_collector: cycle model of arbitration and addressing
// feeding a write scoreboard, a table of full-run spot checks, and hand-written corner cases.
module tb_pim_result_collector;
   import pim_result_collector_pkg::*;

   localparam int N    = NUM_OF_PIM_UNITS;
   localparam int TILE = 16;

   logic                       clk = 1'b0;
   logic                       rst_n;
   logic                       start;
   logic [LEN-1:0]             result_base;
   logic [N-1:0]               pim_valid;
   logic [N-1:0][WIDTH-1:0]    pim_data;
   logic [N-1:0]               pim_ready;
   logic                       mem_we;
   logic [LEN-1:0]             mem_addr;
   logic [WIDTH-1:0]           mem_wdata;
   logic                       busy;
   logic                       done;

   always #5 clk = ~clk;

   pim_result_collector dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .result_base (result_base),
      .pim_valid   (pim_valid),
      .pim_data    (pim_data),
      .pim_ready   (pim_ready),
      .mem_we      (mem_we),
      .mem_addr    (mem_addr),
      .mem_wdata   (mem_wdata),
      .busy        (busy),
      .done        (done)
   );

   typedef struct {
      logic [LEN-1:0]   addr;
      logic [WIDTH-1:0] data;
      int               unit;
      int               elem;
   } wr_t;

   typedef struct {
      logic [LEN-1:0]   base;
      bit               restart;
      int               su;
      int               se;
      logic [LEN-1:0]   exp_addr;
      logic [WIDTH-1:0] exp_data;
   } row_t;

   wr_t            sb[$];
   logic [LEN-1:0] addr_log[$];
   int n_cmp = 0;
   int n_fail = 0;

   int             mstate;
   int             mcnt[N];
   int             mptr;
   logic [LEN-1:0] mbase;

   int cyc = 0;
   int writes_total;
   int writes_unit[N];
   int done_count;
   int last_xfer_cyc;
   int done_cyc;
   int spot_u;
   int spot_e;
   bit spot_seen;
   logic [LEN-1:0]   spot_addr;
   logic [WIDTH-1:0] spot_data;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   function automatic logic [N-1:0] model_grant(input logic [N-1:0] v);
      logic [N-1:0] g;
      int idx;
      g = '0;
      if (mstate == 1) begin
         for (int i = 0; i < N; i++) begin
            idx = (mptr + i) % N;
            if (g == '0 && v[idx] && mcnt[idx] < TILE) g[idx] = 1'b1;
         end
      end
      return g;
   endfunction

   function automatic logic [LEN-1:0] model_addr(input int u, input int e);
      int a;
      a = int'(mbase) + ((u / 2) * 4 + e / 4) * 8 + (u % 2) * 4 + e % 4;
      return LEN'(a % 1024);
   endfunction

   task automatic clear_stats();
      writes_total = 0;
      for (int u = 0; u < N; u++) writes_unit[u] = 0;
      done_count = 0;
      last_xfer_cyc = -100;
      done_cyc = -1000;
      spot_seen = 1'b0;
      spot_addr = '0;
      spot_data = '0;
      addr_log.delete();
   endtask

   // One clock: drive at negedge, check ready, update model, check write port after posedge.
   task automatic do_cycle(input logic [N-1:0] v, input logic st, input logic [LEN-1:0] b,
                           output logic [N-1:0] rdy);
      logic [N-1:0] g;
      wr_t w;
      int u;
      bit full;
      pim_valid   = v;
      start       = st;
      result_base = b;
      for (int k = 0; k < N; k++) pim_data[k] = WIDTH'(k * 100 + mcnt[k]);
      #1;
      g = model_grant(v);
      rdy = pim_ready;
      chk("pim_ready", pim_ready, g);
      case (mstate)
         0: begin
            if (st) begin
               mstate = 1;
               mbase = b;
               for (int k = 0; k < N; k++) mcnt[k] = 0;
            end
         end
         1: begin
            if (g != '0) begin
               u = 0;
               for (int k = 0; k < N; k++) if (g[k]) u = k;
               w.addr = model_addr(u, mcnt[u]);
               w.data = WIDTH'(u * 100 + mcnt[u]);
               w.unit = u;
               w.elem = mcnt[u];
               sb.push_back(w);
               mcnt[u]++;
               mptr = (u + 1) % N;
               full = 1'b1;
               for (int k = 0; k < N; k++) if (mcnt[k] != TILE) full = 1'b0;
               if (full) begin
                  mstate = 2;
                  last_xfer_cyc = cyc;
               end
            end
         end
         2: mstate = 3;
         default: mstate = 0;
      endcase
      @(posedge clk);
      cyc++;
      #1;
      chk("mem_we", {31'd0, mem_we}, {31'd0, sb.size() > 0});
      if (sb.size() > 0) begin
         w = sb.pop_front();
         chk("mem_addr", mem_addr, w.addr);
         chk("mem_wdata", mem_wdata, w.data);
         writes_total++;
         writes_unit[w.unit]++;
         addr_log.push_back(mem_addr);
         if (w.unit == spot_u && w.elem == spot_e) begin
            spot_seen = 1'b1;
            spot_addr = mem_addr;
            spot_data = mem_wdata;
         end
      end
      chk("busy", {31'd0, busy}, {31'd0, (mstate == 1 || mstate == 2)});
      chk("done", {31'd0, done}, {31'd0, mstate == 3});
      if (done) begin
         done_count++;
         done_cyc = cyc;
      end
      @(negedge clk);
   endtask

   // Reset for one cycle with all units still offering data; everything must clear.
   task automatic reset_dut();
      rst_n = 1'b0;
      start = 1'b0;
      pim_valid = '1;
      @(posedge clk);
      cyc++;
      #1;
      mstate = 0;
      mptr = 0;
      mbase = '0;
      for (int k = 0; k < N; k++) mcnt[k] = 0;
      sb.delete();
      chk("rst_pim_ready", pim_ready, '0);
      chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
      chk("rst_mem_addr", mem_addr, '0);
      chk("rst_mem_wdata", mem_wdata, '0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      pim_valid = '0;
   endtask

   task automatic run_full(input row_t r);
      logic [N-1:0] rdy;
      clear_stats();
      spot_u = r.su;
      spot_e = r.se;
      do_cycle(4'hF, 1'b1, r.base, rdy);
      for (int k = 0; k < 200 && done_count == 0; k++) begin
         do_cycle(4'hF, r.restart && k == 10, r.restart ? 10'd500 : r.base, rdy);
      end
      chk("run_writes", writes_total, 32'd64);
      chk("done_latency", done_cyc - last_xfer_cyc, 32'd2);
      do_cycle(4'h0, 1'b0, 10'd0, rdy);
      do_cycle(4'h0, 1'b0, 10'd0, rdy);
      chk("done_once", done_count, 32'd1);
      chk("spot_seen", {31'd0, spot_seen}, 32'd1);
      chk("spot_addr", spot_addr, r.exp_addr);
      chk("spot_data", spot_data, r.exp_data);
   endtask

   initial begin
      row_t rows[6];
      int exp_u2[16];
      logic [N-1:0] rdy;
      int lost;
      bit elig0;

      rows[0] = '{10'd0,    1'b0, 1, 5,  10'd13,   32'd105};
      rows[1] = '{10'd0,    1'b0, 2, 0,  10'd32,   32'd200};
      rows[2] = '{10'd0,    1'b0, 3, 15, 10'd63,   32'd315};
      rows[3] = '{10'd1000, 1'b0, 3, 15, 10'd39,   32'd315};
      rows[4] = '{10'd1000, 1'b0, 0, 0,  10'd1000, 32'd0};
      rows[5] = '{10'd0,    1'b1, 3, 15, 10'd63,   32'd315};
      exp_u2 = '{32, 33, 34, 35, 40, 41, 42, 43, 48, 49, 50, 51, 56, 57, 58, 59};

      rst_n = 1'b0;
      start = 1'b0;
      result_base = '0;
      pim_valid = '0;
      pim_data = '0;
      mstate = 0;
      mptr = 0;
      mbase = '0;
      for (int k = 0; k < N; k++) mcnt[k] = 0;
      spot_u = -1;
      spot_e = -1;
      clear_stats();
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset_dut();

      for (int i = 0; i < 6; i++) run_full(rows[i]);

      // Only unit 2 offers data; its tile lands in the lower-left block, then it is shut out.
      clear_stats();
      do_cycle(4'b0100, 1'b1, 10'd0, rdy);
      for (int k = 0; k < 20; k++) do_cycle(4'b0100, 1'b0, 10'd0, rdy);
      chk("u2_writes", writes_total, 32'd16);
      for (int i = 0; i < 16; i++) begin
         if (i < addr_log.size()) chk("u2_addr", addr_log[i], exp_u2[i]);
         else chk("u2_addr_missing", i, 32'd16);
      end
      chk("u2_ready_after_tile", rdy, '0);
      chk("u2_busy", {31'd0, busy}, 32'd1);
      reset_dut();

      // Abort after 20 transfers, then a fresh full run must complete normally.
      clear_stats();
      do_cycle(4'hF, 1'b1, 10'd0, rdy);
      for (int k = 0; k < 100 && writes_total < 20; k++) do_cycle(4'hF, 1'b0, 10'd0, rdy);
      chk("pre_reset_writes", writes_total, 32'd20);
      reset_dut();
      run_full(rows[1]);

      // Units 0 and 1; unit 1 valid on alternate cycles; unit 0 never waits idle.
      clear_stats();
      lost = 0;
      do_cycle(4'b0011, 1'b1, 10'd0, rdy);
      for (int k = 0; k < 100 && !(mcnt[0] == TILE && mcnt[1] == TILE); k++) begin
         elig0 = (mcnt[0] < TILE);
         do_cycle({2'b00, (k % 2) == 0, 1'b1}, 1'b0, 10'd0, rdy);
         if (elig0 && rdy == '0) lost++;
      end
      chk("alt_unit0_writes", writes_unit[0], 32'd16);
      chk("alt_unit1_writes", writes_unit[1], 32'd16);
      chk("alt_total_writes", writes_total, 32'd32);
      chk("alt_lost_cycles", lost, 32'd0);
      reset_dut();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
